simd_seq_ctrl: RTL and testbench

- Sequencer for one simd_cell temporal-unary MAC array.
- Takes a job of N reduction steps. For each step it accepts one operand beat (input vector plus weight vector) from the upstream feeder.
- Holds the cell enable for one full temporal phase of 2^INPUT_WIDTH cycles, then waits for the product-accumulate pipeline to drain.
- Presents a result-valid handshake downstream, then clears the cell for the next job.

---
 rtl/simd_seq_pkg.sv | 25 ++
 rtl/simd_phase_cnt.sv | 31 +++
 rtl/simd_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_simd_seq_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_seq_pkg.sv
// Shared types and constants for the simd_cell sequencer.
// State codes, phase length and step-width helpers.
`timescale 1ns/1ps
package simd_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_RUN   = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  // Step count needs one extra bit so 2^DIM_B itself is representable.
  localparam int STEP_EXTRA = 1;

  function automatic int phase_len(input int w);
    return 1 << w;
  endfunction

  function automatic int step_w(input int dim_b);
    return dim_b + STEP_EXTRA;
  endfunction

endpackage

// File: rtl/simd_phase_cnt.sv
// Up-counter with enable, sync clear and a last-cycle flag.
// Serves both the temporal phase and the drain interval.
`timescale 1ns/1ps
module simd_phase_cnt
  import simd_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign last = en && (cnt == limit);

endmodule

// File: rtl/simd_seq_ctrl.sv
// Job sequencer for one simd_cell temporal-unary MAC array.
// Optional stall counter: define SIMD_SEQ_CTRL_PERF_EN.
`timescale 1ns/1ps
module simd_seq_ctrl
  import simd_seq_pkg::*;
#(
  parameter int INPUT_WIDTH  = 8,
  parameter int DIM_B        = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_B:0]   cfg_steps,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             op_load,
  output logic             cell_en,
  output logic             cell_clr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [DIM_B-1:0] step_idx
`ifdef SIMD_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int STEP_W = step_w(DIM_B);
  localparam int PLEN   = phase_len(INPUT_WIDTH);

  localparam logic [INPUT_WIDTH-1:0] PHASE_LAST =
    INPUT_WIDTH'(PLEN - 1);
  localparam logic [INPUT_WIDTH-1:0] DRAIN_LAST =
    INPUT_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [STEP_W-1:0] MAX_STEPS =
    STEP_W'(1) << DIM_B;

  state_t state;
  state_t state_d;

  logic [STEP_W-1:0]      steps;
  logic [INPUT_WIDTH-1:0] cnt_limit;
  logic cnt_en;
  logic cnt_clr;
  logic cnt_last;
  logic start_ok;
  logic accept;
  logic final_step;

  assign start_ok = start
    && (cfg_steps != '0)
    && (cfg_steps <= MAX_STEPS);

  assign accept = (state == S_LOAD) && op_valid;

  assign final_step =
    ({1'b0, step_idx} == (steps - STEP_W'(1)));

  assign cnt_en = (state == S_RUN)
    || (state == S_DRAIN);

  assign cnt_limit = (state == S_DRAIN)
    ? DRAIN_LAST : PHASE_LAST;

  // Entering RUN or leaving a phase/drain restarts the count.
  assign cnt_clr = accept || cnt_last;

  simd_phase_cnt #(
    .W (INPUT_WIDTH)
  ) u_phase_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .limit (cnt_limit),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start_ok) state_d = S_LOAD;
      S_LOAD:  if (op_valid) state_d = S_RUN;
      S_RUN: begin
        if (cnt_last)
          state_d = final_step ? S_DRAIN : S_LOAD;
      end
      S_DRAIN: if (cnt_last) state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      steps    <= '0;
      step_idx <= '0;
      op_load  <= 1'b0;
      cell_clr <= 1'b0;
    end else begin
      state    <= state_d;
      op_load  <= accept;
      cell_clr <= (state == S_DONE) && res_ready;
      if ((state == S_IDLE) && start_ok) begin
        steps    <= cfg_steps;
        step_idx <= '0;
      end else if ((state == S_RUN) && cnt_last
                   && !final_step) begin
        step_idx <= step_idx + DIM_B'(1);
      end
    end
  end

  assign op_ready  = (state == S_LOAD);
  assign res_valid = (state == S_DONE);
  assign cell_en   = (state == S_RUN);
  assign busy      = (state != S_IDLE);

`ifdef SIMD_SEQ_CTRL_PERF_EN
  logic stall;

  assign stall = ((state == S_LOAD) && !op_valid)
    || ((state == S_DONE) && !res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == S_IDLE) && start_ok) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// Directed self-checking bench for simd_seq_ctrl.
// Covers latency, gaps, stalls, backpressure, configs, reset.
`timescale 1ns/1ps
module tb_simd_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] cfg_steps = '0;
  logic       op_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic       op_ready;
  logic       op_load;
  logic       cell_en;
  logic       cell_clr;
  logic       res_valid;
  logic       busy;
  logic [3:0] step_idx;
`ifdef SIMD_SEQ_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  int a[16];
  int w[16];

  int r_timeout, r_rv_cyc, r_en, r_bursts, r_gap;
  int r_loads, r_maxstep, r_clr, r_clr_bad;
  int r_rv_rises, r_rv_drop, r_mac, r_ready;
  int r_rv_after, r_busy_after;

  simd_seq_ctrl #(
    .INPUT_WIDTH  (8),
    .DIM_B        (4),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_steps (cfg_steps),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_load   (op_load),
    .cell_en   (cell_en),
    .cell_clr  (cell_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .step_idx  (step_idx)
`ifdef SIMD_SEQ_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job; cycle 0 is the cycle start is presented.
  task automatic run_job(input int steps, input int stall_n,
                         input int bp_n, input int inj);
    int cyc, k, ph, in_r, w_r, gap, stall_c, bp_c, hs_cyc;
    bit hs, done, prev_en, prev_rv;
    cyc = 0; k = 0; ph = 0; in_r = 0; w_r = 0; gap = 0;
    stall_c = 0; bp_c = 0; hs_cyc = 0;
    hs = 0; done = 0; prev_en = 0; prev_rv = 0;
    r_timeout = 0; r_rv_cyc = -1; r_en = 0; r_bursts = 0;
    r_gap = 0; r_loads = 0; r_maxstep = 0; r_clr = 0;
    r_clr_bad = 0; r_rv_rises = 0; r_rv_drop = 0; r_mac = 0;
    r_ready = 0; r_rv_after = -1; r_busy_after = -1;
    op_valid = 1'b1;
    res_ready = 1'b0;
    cfg_steps = 5'(steps);
    start = 1'b1;
    while (!done && cyc < 6000) begin
      step();
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (inj > 1 && cyc == inj) begin
        start = 1'b1;
        cfg_steps = 5'd1;
      end else if (inj > 1 && cyc == inj + 1) begin
        start = 1'b0;
      end
      if (op_load) begin
        if (k < 16) begin
          in_r = a[k];
          w_r = w[k];
        end
        k++;
        ph = 0;
        r_loads++;
      end
      if (cell_en) begin
        if (!prev_en) begin
          r_bursts++;
          if (r_bursts > 1 && gap > r_gap) r_gap = gap;
        end
        if (ph < in_r) r_mac += w_r;
        ph++;
        r_en++;
        gap = 0;
      end else if (r_bursts > 0) begin
        gap++;
      end
      prev_en = cell_en;
      if (int'(step_idx) > r_maxstep) r_maxstep = int'(step_idx);
      if (op_ready) r_ready++;
      if (cell_clr) begin
        r_clr++;
        if (!(hs && cyc == hs_cyc + 1)) r_clr_bad++;
      end
      if (res_valid && !prev_rv) begin
        r_rv_rises++;
        if (r_rv_cyc < 0) r_rv_cyc = cyc;
      end
      if (prev_rv && !res_valid && !hs) r_rv_drop++;
      prev_rv = res_valid;
      if (hs && cyc == hs_cyc + 1) begin
        r_rv_after = int'(res_valid);
        r_busy_after = int'(busy);
      end
      if (op_ready && step_idx == 4'd1 && stall_c < stall_n) begin
        op_valid = 1'b0;
        stall_c++;
      end else begin
        op_valid = 1'b1;
      end
      if (res_valid && !hs) begin
        if (bp_c < bp_n) begin
          res_ready = 1'b0;
          bp_c++;
        end else begin
          res_ready = 1'b1;
          hs = 1;
          hs_cyc = cyc;
        end
      end else begin
        res_ready = 1'b0;
      end
      if (hs && cyc == hs_cyc + 3) done = 1;
    end
    if (!done) r_timeout = 1;
    start = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy);
    else n_pass++;
    n_total++;
    if (cell_en !== 1'b0) $display("FAIL reset_cell_en got %0b want 0", cell_en);
    else n_pass++;
    n_total++;
    if (op_ready !== 1'b0) $display("FAIL reset_op_ready got %0b want 0", op_ready);
    else n_pass++;
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %0b want 0", res_valid);
    else n_pass++;
    n_total++;
    if (op_load !== 1'b0) $display("FAIL reset_op_load got %0b want 0", op_load);
    else n_pass++;
    n_total++;
    if (cell_clr !== 1'b0) $display("FAIL reset_cell_clr got %0b want 0", cell_clr);
    else n_pass++;
    n_total++;
    if (step_idx !== 4'd0) $display("FAIL reset_step_idx got %0d want 0", step_idx);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    a[0] = 200; w[0] = 3;
    run_job(1, 0, 0, 0);
    n_total++;
    if (r_timeout !== 0) $display("FAIL single_timeout got %0d want 0", r_timeout);
    else n_pass++;
    n_total++;
    if (r_rv_cyc !== 261) $display("FAIL single_latency got %0d want 261", r_rv_cyc);
    else n_pass++;
    n_total++;
    if (r_en !== 256) $display("FAIL single_en_cycles got %0d want 256", r_en);
    else n_pass++;
    n_total++;
    if (r_loads !== 1) $display("FAIL single_loads got %0d want 1", r_loads);
    else n_pass++;
    n_total++;
    if (r_clr !== 1) $display("FAIL single_clr_pulses got %0d want 1", r_clr);
    else n_pass++;
    n_total++;
    if (r_clr_bad !== 0) $display("FAIL single_clr_timing got %0d want 0", r_clr_bad);
    else n_pass++;
    n_total++;
    if (r_mac !== 600) $display("FAIL single_mac got %0d want 600", r_mac);
    else n_pass++;
    n_total++;
    if (r_rv_after !== 0) $display("FAIL single_rv_drop got %0d want 0", r_rv_after);
    else n_pass++;
    n_total++;
    if (r_busy_after !== 0) $display("FAIL single_idle got %0d want 0", r_busy_after);
    else n_pass++;
  endtask

  task automatic test_four();
    a[0] = 10;  w[0] = 1;
    a[1] = 0;   w[1] = 7;
    a[2] = 255; w[2] = 2;
    a[3] = 128; w[3] = 3;
    run_job(4, 0, 0, 100);
    n_total++;
    if (r_rv_cyc !== 1032) $display("FAIL four_latency got %0d want 1032", r_rv_cyc);
    else n_pass++;
    n_total++;
    if (r_en !== 1024) $display("FAIL four_en_cycles got %0d want 1024", r_en);
    else n_pass++;
    n_total++;
    if (r_bursts !== 4) $display("FAIL four_bursts got %0d want 4", r_bursts);
    else n_pass++;
    n_total++;
    if (r_gap !== 1) $display("FAIL four_gap got %0d want 1", r_gap);
    else n_pass++;
    n_total++;
    if (r_loads !== 4) $display("FAIL four_loads got %0d want 4", r_loads);
    else n_pass++;
    n_total++;
    if (r_maxstep !== 3) $display("FAIL four_step_idx got %0d want 3", r_maxstep);
    else n_pass++;
    n_total++;
    if (r_rv_rises !== 1) $display("FAIL four_rv_rises got %0d want 1", r_rv_rises);
    else n_pass++;
    n_total++;
    if (r_ready !== 4) $display("FAIL four_ready_cycles got %0d want 4", r_ready);
    else n_pass++;
    n_total++;
    if (r_mac !== 904) $display("FAIL four_mac got %0d want 904", r_mac);
    else n_pass++;
  endtask

  task automatic test_feeder_stall();
    a[0] = 100; w[0] = 5;
    a[1] = 50;  w[1] = 9;
    run_job(2, 10, 0, 0);
    n_total++;
    if (r_rv_cyc !== 528) $display("FAIL stall_latency got %0d want 528", r_rv_cyc);
    else n_pass++;
    n_total++;
    if (r_gap !== 11) $display("FAIL stall_gap got %0d want 11", r_gap);
    else n_pass++;
    n_total++;
    if (r_ready !== 12) $display("FAIL stall_ready_cycles got %0d want 12", r_ready);
    else n_pass++;
    n_total++;
    if (r_en !== 512) $display("FAIL stall_en_cycles got %0d want 512", r_en);
    else n_pass++;
    n_total++;
    if (r_mac !== 950) $display("FAIL stall_mac got %0d want 950", r_mac);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    a[0] = 1; w[0] = 11;
    a[1] = 2; w[1] = 13;
    run_job(2, 10, 20, 535);
    n_total++;
    if (r_rv_cyc !== 528) $display("FAIL bp_latency got %0d want 528", r_rv_cyc);
    else n_pass++;
    n_total++;
    if (r_rv_drop !== 0) $display("FAIL bp_rv_held got %0d want 0", r_rv_drop);
    else n_pass++;
    n_total++;
    if (r_clr_bad !== 0) $display("FAIL bp_early_clr got %0d want 0", r_clr_bad);
    else n_pass++;
    n_total++;
    if (r_clr !== 1) $display("FAIL bp_clr_pulses got %0d want 1", r_clr);
    else n_pass++;
    n_total++;
    if (r_busy_after !== 0) $display("FAIL bp_start_ignored got %0d want 0", r_busy_after);
    else n_pass++;
    n_total++;
    if (r_mac !== 37) $display("FAIL bp_mac got %0d want 37", r_mac);
    else n_pass++;
`ifdef SIMD_SEQ_CTRL_PERF_EN
    n_total++;
    if (stall_cnt !== 32'd30) $display("FAIL bp_stall_cnt got %0d want 30", stall_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_illegal();
    cfg_steps = 5'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL illegal_zero got %0b want 0", busy);
    else n_pass++;
    cfg_steps = 5'd17;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL illegal_17 got %0b want 0", busy);
    else n_pass++;
    run_job(16, 0, 0, 0);
    n_total++;
    if (r_rv_cyc !== 4116) $display("FAIL max_latency got %0d want 4116", r_rv_cyc);
    else n_pass++;
    n_total++;
    if (r_loads !== 16) $display("FAIL max_loads got %0d want 16", r_loads);
    else n_pass++;
    n_total++;
    if (r_maxstep !== 15) $display("FAIL max_step_idx got %0d want 15", r_maxstep);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int en_seen;
    int guard;
    en_seen = 0;
    guard = 0;
    op_valid = 1'b1;
    cfg_steps = 5'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (en_seen < 100 && guard < 400) begin
      step();
      guard++;
      if (cell_en) en_seen++;
    end
    n_total++;
    if (en_seen !== 100) $display("FAIL rst_reach_phase got %0d want 100", en_seen);
    else n_pass++;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (cell_en !== 1'b0) $display("FAIL rst_cell_en got %0b want 0", cell_en);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy);
    else n_pass++;
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %0b want 0", res_valid);
    else n_pass++;
    n_total++;
    if (op_ready !== 1'b0) $display("FAIL rst_op_ready got %0b want 0", op_ready);
    else n_pass++;
    step();
    n_total++;
    if (cell_clr !== 1'b0) $display("FAIL rst_no_clr got %0b want 0", cell_clr);
    else n_pass++;
    rst_n = 1'b1;
    step();
    a[0] = 7; w[0] = 4;
    run_job(1, 0, 0, 0);
    n_total++;
    if (r_rv_cyc !== 261) $display("FAIL rst_rejob_latency got %0d want 261", r_rv_cyc);
    else n_pass++;
    n_total++;
    if (r_clr !== 1) $display("FAIL rst_rejob_clr got %0d want 1", r_clr);
    else n_pass++;
    n_total++;
    if (r_mac !== 28) $display("FAIL rst_rejob_mac got %0d want 28", r_mac);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      a[i] = 0;
      w[i] = 0;
    end
    test_reset();
    test_single();
    test_four();
    test_feeder_stall();
    test_backpressure();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
